// File: rtl/eka_pkg.sv
// eka_pkg: shared core typedefs and constants used across the eka pipeline.
package eka_pkg;
  localparam int INSTR_W = 32;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetch with a one-entry instruction buffer.
module ifetch_unit
  import eka_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-3:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-3:0] pc,
  input  logic                  flush,
  output logic                  stall_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  instr_t                imem_rsp_data,
  output logic                  instr_valid,
  output instr_t                instr,
  output logic [ADDR_WIDTH-3:0] instr_pc,
  input  logic                  instr_ready
);
  fetch_state_e state, state_nxt;
  logic [ADDR_WIDTH-3:0] req_pc;
  logic discard;
  logic rsp_take;
  assign rsp_take = state == WAIT && imem_rsp_valid && !discard && !flush;
  always_ff @(posedge clk) begin
    if (reset) state <= REQ;
    else       state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      REQ:     state_nxt = imem_req_ready ? WAIT : REQ;
      WAIT:    state_nxt = !imem_rsp_valid ? WAIT : (rsp_take ? HOLD : REQ);
      HOLD:    state_nxt = (instr_ready || flush) ? REQ : HOLD;
      default: state_nxt = REQ;
    endcase
  end
  always_comb begin
    imem_req_valid = state == REQ;
    instr_valid    = state == HOLD;
  end
  assign imem_req_addr = pc;
  assign stall_pc      = ~(instr_valid & instr_ready & ~flush);
  // A flush while the response is still in flight is remembered so that response is dropped on arrival.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc   <= RESET_ADDR;
      discard  <= 1'b0;
      instr    <= '0;
      instr_pc <= RESET_ADDR;
    end else begin
      if (state == REQ && imem_req_ready) begin
        req_pc  <= pc;
        discard <= 1'b0;
      end
      if (state == WAIT && flush && !imem_rsp_valid) discard <= 1'b1;
      if (rsp_take) begin
        instr    <= imem_rsp_data;
        instr_pc <= req_pc;
      end
    end
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be: default 32; byte-address width, with word addresses ADDR_WIDTH-2 bits wide.
REQ-002 Parameter RESET_ADDR SHALL be: default 30'h0000_0000; reset value of instr_pc, as a word address.
REQ-003 Port clk SHALL be: input, 1 bit; clock, all state updates on rising edge.
REQ-004 Port reset SHALL be: input, 1 bit; reset, synchronous, active-high.
REQ-005 Port pc SHALL be: input, ADDR_WIDTH-2 bits; current word PC from the PC stage.
REQ-006 Port flush SHALL be: input, 1 bit; kill the buffered and in-flight fetch.
REQ-007 Port stall_pc SHALL be: output, 1 bit; drives the PC stage stall input.
REQ-008 Port imem_req_valid SHALL be: output, 1 bit; instruction memory request valid.
REQ-009 Port imem_req_ready SHALL be: input, 1 bit; memory accepts the request.
REQ-010 Port imem_req_addr SHALL be: output, ADDR_WIDTH-2 bits; request word address.
REQ-011 Port imem_rsp_valid SHALL be: input, 1 bit; response data valid.
REQ-012 Port imem_rsp_data SHALL be: input, 32 bits; fetched instruction.
REQ-013 Port instr_valid SHALL be: output, 1 bit; instr and instr_pc are valid.
REQ-014 Port instr SHALL be: output, 32 bits; buffered instruction.
REQ-015 Port instr_pc SHALL be: output, ADDR_WIDTH-2 bits; word PC of instr.
REQ-016 Port instr_ready SHALL be: input, 1 bit; downstream consumes instr this cycle.

Function
REQ-017 The FSM SHALL have exactly three states: REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-018 In REQ, the block SHALL drive imem_req_valid=1 and imem_req_addr=pc; in other states, imem_req_valid SHALL be 0.
REQ-019 In REQ, on imem_req_ready=1, the block SHALL latch pc into req_pc, clear discard, and move to WAIT.
REQ-020 In WAIT, on imem_rsp_valid=1 with discard=0 and flush=0, the block SHALL register instr<=imem_rsp_data, instr_pc<=req_pc, set instr_valid=1, and move to HOLD.
REQ-021 In WAIT, on imem_rsp_valid=1 with discard=1 or flush=1, the block SHALL drop the data and move to REQ.
REQ-022 In WAIT, on flush=1 without imem_rsp_valid, the block SHALL set discard=1 and stay in WAIT until the response arrives.
REQ-023 In HOLD, on instr_ready=1 and flush=0, the block SHALL clear instr_valid and move to REQ.
REQ-024 In HOLD, on flush=1 (regardless of instr_ready), the block SHALL clear instr_valid and move to REQ, with no consume.
REQ-025 In REQ, flush SHALL have no effect.
REQ-026 stall_pc SHALL be combinational and equal ~(instr_valid & instr_ready & ~flush); the PC therefore advances exactly once per consumed instruction.
REQ-027 imem_req_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0; this is guaranteed because pc is held by stall_pc.
REQ-028 imem_rsp_valid SHALL be ignored outside WAIT.
REQ-029 Minimum latency SHALL be: request accepted in cycle N, response in N+1, instr_valid=1 in N+2.
REQ-030 Back-to-back throughput SHALL be one instruction per 3 cycles with zero-wait memory; no prefetch.

Reset
REQ-031 On reset, the block SHALL set state=REQ, instr_valid=0, instr=32'h0000_0000, instr_pc=RESET_ADDR, discard=0, req_pc=RESET_ADDR.
REQ-032 Reset SHALL override all inputs, including mid-WAIT; the memory shares reset, so no pre-reset response returns.

Structure
REQ-033 The fetch state enum (REQ, WAIT, HOLD) SHALL live in the shared eka_pkg package alongside other core typedefs.
REQ-034 The block SHALL be a single module with no sub-module; the buffer is a single register stage.

Verification
REQ-035 Scenario: reset; ready=1; response 0x00500093 one cycle later -> instr_valid=1 in the 3rd cycle after reset release, instr=0x00500093, instr_pc=0.
REQ-036 Scenario: imem_req_ready held 0 for 4 cycles -> imem_req_valid=1 and imem_req_addr constant throughout; stall_pc=1 throughout.
REQ-037 Scenario: instr_valid=1 with instr_ready=0 for 3 cycles -> instr held; stall_pc=1; instr_ready=1 -> stall_pc=0 for exactly 1 cycle.
REQ-038 Scenario: flush in WAIT, response 2 cycles later -> response dropped; instr_valid stays 0; new request to the current pc.
REQ-039 Scenario: flush and instr_ready both 1 in HOLD -> instr_valid=0 next cycle; stall_pc=1 in that cycle; state=REQ.
REQ-040 Scenario: reset asserted in WAIT -> next cycle state=REQ, instr_valid=0, instr_pc=RESET_ADDR.
